// File: rtl/v_pkg.sv
// Shared types for the v list engine and its multi-channel update ingress.
// Update fields travel as one packed upd_t so FIFOs and issue registers stay uniform.
package v_pkg;

    localparam int UPD_MUX_N_CH_MAX = 16;

    typedef logic [7:0]  id_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_INS = 2'd1,
        CMD_DEL = 2'd2,
        CMD_MOD = 2'd3
    } cmd_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

endpackage

// File: rtl/v_upd_mux_fifo.sv
// Single-channel update FIFO for v_upd_mux: owns pointers, occupancy,
// registered ready and the sticky overflow flag for one producer.
module v_upd_mux_fifo
    import v_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic clk,
    input  logic arst_n,
    input  logic i_vld,
    input  upd_t i_data,
    input  logic i_pop,
    output logic o_rdy_r,
    output logic o_ovf_r,
    output logic o_nempty,
    output upd_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    upd_t          r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign w_push       = i_vld & o_rdy_r;
    assign w_pop        = i_pop & (r_count != '0);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign o_nempty     = (r_count != '0);
    assign o_head       = r_mem[r_rptr];

    // Ready looks at the post-update count, so a full FIFO stays unready for
    // the cycle it is drained and reopens one edge later.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            o_rdy_r <= 1'b0;
            o_ovf_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (i_vld && !o_rdy_r) begin
                o_ovf_r <= 1'b1;
            end
            r_count <= w_count_next;
            o_rdy_r <= (w_count_next < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/v_upd_mux.sv
// Multi-channel update ingress for the v engine: per-channel FIFOs feeding a
// busy-gated round-robin issue stage. Optional per-channel issue counters: V_UPD_MUX_STATS_EN.
module v_upd_mux
    import v_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
)
(
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [N_CH-1:0]          i_ch_vld,
    input  id_t                      i_ch_prod_id [N_CH],
    input  cmd_t                     i_ch_cmd     [N_CH],
    input  key_t                     i_ch_key     [N_CH],
    input  size_t                    i_ch_size    [N_CH],
    output logic [N_CH-1:0]          o_ch_rdy_r,
    output logic [N_CH-1:0]          o_ch_ovf_r,
    input  logic                     i_busy_r,
    output logic                     o_upd_vld_r,
    output id_t                      o_upd_prod_id_r,
    output cmd_t                     o_upd_cmd_r,
    output key_t                     o_upd_key_r,
    output size_t                    o_upd_size_r,
    output logic [$clog2(N_CH)-1:0]  o_upd_ch_r
`ifdef V_UPD_MUX_STATS_EN
    ,
    output logic [CNT_W-1:0]         o_stat_issued_r [N_CH]
`endif
);

    localparam int CH_W = $clog2(N_CH);

    if (N_CH < 2 || N_CH > UPD_MUX_N_CH_MAX || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_err
        $error("v_upd_mux: illegal parameter set");
    end

    logic [N_CH-1:0] w_nonempty;
    logic [N_CH-1:0] w_pop;
    upd_t            w_head [N_CH];
    logic [CH_W-1:0] w_cand [N_CH];
    logic [CH_W-1:0] r_rr_ptr;
    logic            w_grant_vld;
    logic [CH_W-1:0] w_grant;
    upd_t            r_upd;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        upd_t w_in;

        assign w_in.prod_id = i_ch_prod_id[c];
        assign w_in.cmd     = i_ch_cmd[c];
        assign w_in.key     = i_ch_key[c];
        assign w_in.size    = i_ch_size[c];
        assign w_pop[c]     = w_grant_vld & (w_grant == CH_W'(c));
        assign w_cand[c]    = CH_W'((int'(r_rr_ptr) + c) % N_CH);

        v_upd_mux_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .arst_n   (arst_n),
            .i_vld    (i_ch_vld[c]),
            .i_data   (w_in),
            .i_pop    (w_pop[c]),
            .o_rdy_r  (o_ch_rdy_r[c]),
            .o_ovf_r  (o_ch_ovf_r[c]),
            .o_nempty (w_nonempty[c]),
            .o_head   (w_head[c])
        );
    end

    // Scan candidates from farthest to nearest so the first non-empty channel
    // at or after rr_ptr is the one left standing.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = r_rr_ptr;
        if (!i_busy_r) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (w_nonempty[w_cand[i]]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_cand[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rr_ptr    <= '0;
            o_upd_vld_r <= 1'b0;
            o_upd_ch_r  <= '0;
            r_upd       <= '0;
        end else begin
            o_upd_vld_r <= w_grant_vld;
            if (w_grant_vld) begin
                r_upd      <= w_head[w_grant];
                o_upd_ch_r <= w_grant;
                r_rr_ptr   <= CH_W'((int'(w_grant) + 1) % N_CH);
            end
        end
    end

    assign o_upd_prod_id_r = r_upd.prod_id;
    assign o_upd_cmd_r     = r_upd.cmd;
    assign o_upd_key_r     = r_upd.key;
    assign o_upd_size_r    = r_upd.size;

`ifdef V_UPD_MUX_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                o_stat_issued_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_pop[c]) begin
                    o_stat_issued_r[c] <= o_stat_issued_r[c] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_v_upd_mux.sv
// Scoreboard bench for v_upd_mux: a queue-based reference model predicts issues,
// a negedge monitor pops and compares. Exercises counters when V_UPD_MUX_STATS_EN is set.
`timescale 1ns/1ps
module tb_v_upd_mux;
    import v_pkg::*;

    localparam int N_CH       = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef V_UPD_MUX_STATS_EN
    localparam int CNT_W      = 8;
`else
    localparam int CNT_W      = 32;
`endif
    localparam int CH_W       = $clog2(N_CH);

    typedef struct packed {
        upd_t            u;
        logic [CH_W-1:0] ch;
    } exp_t;

    logic              clk      = 1'b0;
    logic              arst_n   = 1'b0;
    logic [N_CH-1:0]   i_ch_vld = '0;
    id_t               i_ch_prod_id [N_CH];
    cmd_t              i_ch_cmd     [N_CH];
    key_t              i_ch_key     [N_CH];
    size_t             i_ch_size    [N_CH];
    logic              i_busy_r = 1'b0;
    logic [N_CH-1:0]   o_ch_rdy_r;
    logic [N_CH-1:0]   o_ch_ovf_r;
    logic              o_upd_vld_r;
    id_t               o_upd_prod_id_r;
    cmd_t              o_upd_cmd_r;
    key_t              o_upd_key_r;
    size_t             o_upd_size_r;
    logic [CH_W-1:0]   o_upd_ch_r;
`ifdef V_UPD_MUX_STATS_EN
    logic [CNT_W-1:0]  o_stat_issued_r [N_CH];
`endif

    int total     = 0;
    int bad       = 0;
    int issueSeen = 0;
    int contChs [5] = '{0, 1, 2, 3, 1};

    // Reference model state: one queue per channel plus the expected issue stream.
    upd_t            chQ [N_CH][$];
    exp_t            expQ [$];
    logic [N_CH-1:0] mRdy = '0;
    logic [N_CH-1:0] mOvf = '0;
    logic            mVld = 1'b0;
    int              rr   = 0;
    int              issued [N_CH];

    always #5 clk = ~clk;

    v_upd_mux #(
        .N_CH       (N_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .i_ch_vld        (i_ch_vld),
        .i_ch_prod_id    (i_ch_prod_id),
        .i_ch_cmd        (i_ch_cmd),
        .i_ch_key        (i_ch_key),
        .i_ch_size       (i_ch_size),
        .o_ch_rdy_r      (o_ch_rdy_r),
        .o_ch_ovf_r      (o_ch_ovf_r),
        .i_busy_r        (i_busy_r),
        .o_upd_vld_r     (o_upd_vld_r),
        .o_upd_prod_id_r (o_upd_prod_id_r),
        .o_upd_cmd_r     (o_upd_cmd_r),
        .o_upd_key_r     (o_upd_key_r),
        .o_upd_size_r    (o_upd_size_r),
        .o_upd_ch_r      (o_upd_ch_r)
`ifdef V_UPD_MUX_STATS_EN
        ,
        .o_stat_issued_r (o_stat_issued_r)
`endif
    );

    // Each edge: grant from entries already queued, then accept or drop new offers.
    always @(posedge clk or negedge arst_n) begin
        int   g;
        upd_t u;
        exp_t e;
        if (!arst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                chQ[c].delete();
                issued[c] = 0;
            end
            expQ.delete();
            mRdy = '0;
            mOvf = '0;
            mVld = 1'b0;
            rr   = 0;
        end else begin
            g = -1;
            if (!i_busy_r) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (g < 0 && chQ[(rr + k) % N_CH].size() > 0) g = (rr + k) % N_CH;
                end
            end
            mVld = (g >= 0);
            if (g >= 0) begin
                e.u  = chQ[g].pop_front();
                e.ch = CH_W'(g);
                expQ.push_back(e);
                rr = (g + 1) % N_CH;
                issued[g]++;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (i_ch_vld[c]) begin
                    if (mRdy[c]) begin
                        u.prod_id = i_ch_prod_id[c];
                        u.cmd     = i_ch_cmd[c];
                        u.key     = i_ch_key[c];
                        u.size    = i_ch_size[c];
                        chQ[c].push_back(u);
                    end else begin
                        mOvf[c] = 1'b1;
                    end
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                mRdy[c] = (chQ[c].size() < FIFO_DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        total++;
        if (o_upd_vld_r !== mVld) begin
            bad++;
            $display("[TB] FAIL upd_vld act=%0b exp=%0b t=%0t", o_upd_vld_r, mVld, $time);
        end
        total++;
        if (o_ch_rdy_r !== mRdy) begin
            bad++;
            $display("[TB] FAIL ch_rdy act=%b exp=%b t=%0t", o_ch_rdy_r, mRdy, $time);
        end
        total++;
        if (o_ch_ovf_r !== mOvf) begin
            bad++;
            $display("[TB] FAIL ch_ovf act=%b exp=%b t=%0t", o_ch_ovf_r, mOvf, $time);
        end
        if (o_upd_vld_r === 1'b1) begin
            issueSeen++;
            a.u.prod_id = o_upd_prod_id_r;
            a.u.cmd     = o_upd_cmd_r;
            a.u.key     = o_upd_key_r;
            a.u.size    = o_upd_size_r;
            a.ch        = o_upd_ch_r;
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL upd_unexpected act=0x%0h exp=none t=%0t", a, $time);
            end else begin
                e = expQ.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("[TB] FAIL upd_data act=0x%0h exp=0x%0h t=%0t", a, e, $time);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] vld, input logic busy);
        @(negedge clk);
        i_ch_vld = vld;
        i_busy_r = busy;
        for (int c = 0; c < N_CH; c++) begin
            i_ch_prod_id[c] = id_t'($urandom);
            i_ch_cmd[c]     = cmd_t'($urandom_range(0, 3));
            i_ch_key[c]     = key_t'($urandom);
            i_ch_size[c]    = size_t'($urandom);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        i_ch_vld = '0;
        i_busy_r = 1'b0;
        #2 arst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_rdy", 64'(o_ch_rdy_r), 64'd0);
        checkOutput("rst_ovf", 64'(o_ch_ovf_r), 64'd0);
        checkOutput("rst_vld", 64'(o_upd_vld_r), 64'd0);
        checkOutput("rst_ch", 64'(o_upd_ch_r), 64'd0);
        checkOutput("rst_key", 64'(o_upd_key_r), 64'd0);
        #2 arst_n = 1'b1;
        @(negedge clk);
        checkOutput("rdy_after_rst", 64'(o_ch_rdy_r), 64'(N_CH'('1)));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog act=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        for (int c = 0; c < N_CH; c++) begin
            i_ch_prod_id[c] = '0;
            i_ch_cmd[c]     = CMD_NOP;
            i_ch_key[c]     = '0;
            i_ch_size[c]    = '0;
        end

        $display("[TB] single channel latency");
        resetDut();
        applyStimulus(4'b0001, 1'b0);
        i_ch_prod_id[0] = 8'd3;
        i_ch_cmd[0]     = CMD_INS;
        i_ch_key[0]     = 16'h0010;
        i_ch_size[0]    = 16'd5;
        applyStimulus('0, 1'b0);
        checkOutput("single_early", 64'(o_upd_vld_r), 64'd0);
        applyStimulus('0, 1'b0);
        checkOutput("single_vld", 64'(o_upd_vld_r), 64'd1);
        checkOutput("single_prod", 64'(o_upd_prod_id_r), 64'd3);
        checkOutput("single_key", 64'(o_upd_key_r), 64'h10);
        checkOutput("single_size", 64'(o_upd_size_r), 64'd5);
        checkOutput("single_ch", 64'(o_upd_ch_r), 64'd0);
        applyStimulus('0, 1'b0);
        checkOutput("single_pulse", 64'(o_upd_vld_r), 64'd0);
        checkOutput("single_hold", 64'(o_upd_prod_id_r), 64'd3);

        $display("[TB] contention");
        resetDut();
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus('0, 1'b0);
            checkOutput("cont_vld", 64'(o_upd_vld_r), 64'd1);
            checkOutput("cont_ch", 64'(o_upd_ch_r), 64'(contChs[k]));
        end
        applyStimulus('0, 1'b0);
        checkOutput("cont_idle", 64'(o_upd_vld_r), 64'd0);

        $display("[TB] busy gating");
        resetDut();
        applyStimulus(4'b0111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus('0, 1'b1);
            checkOutput("busy_hold", 64'(o_upd_vld_r), 64'd0);
        end
        applyStimulus('0, 1'b0);
        checkOutput("busy_last", 64'(o_upd_vld_r), 64'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, 1'b0);
            checkOutput("busy_vld", 64'(o_upd_vld_r), 64'd1);
            checkOutput("busy_ch", 64'(o_upd_ch_r), 64'(k));
        end

        $display("[TB] full and overflow");
        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b0100, 1'b1);
            if (i == 7) checkOutput("full_rdy_before", 64'(o_ch_rdy_r[2]), 64'd1);
            if (i == 8) checkOutput("full_rdy", 64'(o_ch_rdy_r[2]), 64'd0);
        end
        applyStimulus('0, 1'b1);
        checkOutput("ovf_set", 64'(o_ch_ovf_r[2]), 64'd1);
        base = issueSeen;
        for (int k = 0; k < 12; k++) begin
            applyStimulus('0, 1'b0);
        end
        checkOutput("ovf_sticky", 64'(o_ch_ovf_r[2]), 64'd1);
        checkOutput("ovf_issued", 64'(issueSeen - base), 64'd8);

        $display("[TB] reset mid-operation");
        resetDut();
        applyStimulus(4'b1111, 1'b0);
        applyStimulus('0, 1'b0);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        checkOutput("midrst_vld", 64'(o_upd_vld_r), 64'd0);
        checkOutput("midrst_rdy", 64'(o_ch_rdy_r), 64'd0);
        checkOutput("midrst_prod", 64'(o_upd_prod_id_r), 64'd0);
        checkOutput("midrst_size", 64'(o_upd_size_r), 64'd0);
        @(negedge clk);
        #2 arst_n = 1'b1;
        base = issueSeen;
        @(negedge clk);
        checkOutput("midrst_rdy_back", 64'(o_ch_rdy_r), 64'(N_CH'('1)));
        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, 1'b0);
        end
        checkOutput("midrst_no_stale", 64'(issueSeen - base), 64'd0);

        $display("[TB] randomized traffic");
        resetDut();
        for (int k = 0; k < 1500; k++) begin
            if (k < 750) applyStimulus(N_CH'($urandom), ($urandom_range(0, 3) == 0));
            else         applyStimulus(N_CH'($urandom & $urandom), ($urandom_range(0, 1) == 0));
        end
        for (int k = 0; k < 60; k++) begin
            applyStimulus('0, 1'b0);
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

`ifdef V_UPD_MUX_STATS_EN
        $display("[TB] issue counters");
        resetDut();
        for (int k = 0; k < 300; k++) begin
            applyStimulus(4'b0010, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus('0, 1'b0);
        end
        checkOutput("stat_ch1", 64'(o_stat_issued_r[1]), 64'd44);
        for (int c = 0; c < N_CH; c++) begin
            checkOutput("stat_model", 64'(o_stat_issued_r[c]), 64'(issued[c] % (1 << CNT_W)));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v_upd_mux.md
# v_upd_mux

Multi-channel update ingress for the `v` list engine. Accepts list updates from `N_CH` independent producers, buffers each channel in its own FIFO, and issues one update per cycle onto the engine's single update bus using round-robin arbitration. Issue is gated by the engine's busy status. Sits directly in front of `v` and generalises the single-producer update bus to `N_CH` channels with per-channel flow control and overflow reporting.

## Interface
Parameters:
- `N_CH`, 4: number of producer channels, 2..16.
- `FIFO_DEPTH`, 8: entries per channel FIFO; power of two, at least 2.
- `CNT_W`, 32: statistics counter width; used only when stats are compiled in.

Ports:
- `clk`  in  1  clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `i_ch_vld`  in  N_CH  per-channel update valid.
- `i_ch_prod_id`  in  N_CH x `v_pkg::id_t`  product id.
- `i_ch_cmd`  in  N_CH x `v_pkg::cmd_t`  command.
- `i_ch_key`  in  N_CH x `v_pkg::key_t`  key.
- `i_ch_size`  in  N_CH x `v_pkg::size_t`  size.
- `o_ch_rdy_r`  out  N_CH  channel FIFO can accept.
- `o_ch_ovf_r`  out  N_CH  sticky overflow: an update was offered while not ready.
- `i_busy_r`  in  1  engine busy; driven from `v.o_busy_r`.
- `o_upd_vld_r`  out  1  update issued to the engine.
- `o_upd_prod_id_r`, `o_upd_cmd_r`, `o_upd_key_r`, `o_upd_size_r`  out  `v_pkg` types  issued update fields.
- `o_upd_ch_r`  out  $clog2(N_CH)  source channel of the issued update.
- `o_stat_issued_r`  out  N_CH x CNT_W  issued-update count per channel. Present only with `V_UPD_MUX_STATS_EN`.

## Operation
- Push: channel c pushes when `i_ch_vld[c] & o_ch_rdy_r[c]`.
- Overflow: `i_ch_vld[c] & !o_ch_rdy_r[c]` drops the update and sets `o_ch_ovf_r[c]`. The bit stays set until reset.
- Ready update: `o_ch_rdy_r[c]` is registered. Its next value is `count_next[c] < FIFO_DEPTH`.
  - Push and pop on the same channel in one cycle are legal; the count is unchanged.
  - A full FIFO deasserts ready even if it is popped that cycle. Ready returns the following cycle.
- Arbitration: occurs each cycle in which `i_busy_r == 0` and at least one FIFO is non-empty.
  - Search starts at channel `rr_ptr` and proceeds upward, modulo N_CH. The first non-empty channel is granted and popped.
  - After a grant, `rr_ptr` becomes `(grant+1) mod N_CH`.
  - `rr_ptr` is unchanged in cycles without a grant. It resets to 0.
- Busy: `i_busy_r == 1` blocks arbitration for that cycle. No pop occurs, and `o_upd_vld_r` is 0 in the next cycle.
- No bypass: a pushed entry is only visible to the arbiter from the cycle after the push.
- Issue: on a grant, the granted entry and channel index are registered onto the `o_upd_*` outputs. `o_upd_vld_r` is a one-cycle pulse per update.
- Data registers hold their last value when `o_upd_vld_r == 0`.
- Pointer wrap: FIFO read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. The occupancy count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `o_ch_rdy_r` = 0. All bits rise at the first clock edge after `arst_n` deasserts.
  - `o_ch_ovf_r`, `o_upd_vld_r`, all `o_upd_*` data, `o_upd_ch_r` and `o_stat_issued_r` = 0.
  - All FIFOs are empty and `rr_ptr` = 0.
- Latency: a push accepted in cycle t into an empty FIFO, with no contention and no busy, gives `o_upd_vld_r` high in cycle t+2.
- Throughput: one issue per cycle across all channels. Each channel is guaranteed at least one issue per N_CH non-busy arbitration cycles.
- Reset asserted mid-operation: FIFO contents, overflow flags and counters are cleared asynchronously. Any in-flight issue is discarded.

## Configuration
- `V_UPD_MUX_STATS_EN` defined: each channel has a CNT_W-bit counter that increments on every issue from that channel. Counters wrap modulo 2^CNT_W. The `o_stat_issued_r` port exists.
- `V_UPD_MUX_STATS_EN` undefined: no counters and no `o_stat_issued_r` port. All other behaviour is identical.

## Structure
- In `v_pkg`: `upd_t` struct (`prod_id`, `cmd`, `key`, `size`) and a `UPD_MUX_N_CH_MAX` = 16 constant.
- Sub-module `v_upd_mux_fifo`: single-channel FIFO storing `upd_t`. It owns its pointers, count, registered ready and sticky overflow flag, and is instantiated N_CH times.
- Round-robin arbiter, issue registers and statistics counters live in `v_upd_mux`.

## Test plan
- Single channel: push to ch0 (prod_id=3, key=0x10, size=5) at cycle 10 → `o_upd_vld_r` high at cycle 12 with those fields and `o_upd_ch_r` = 0.
- Contention: one entry pushed to each of ch0..3 in the same cycle → issues on 4 consecutive cycles in order ch0, ch1, ch2, ch3. A further push to ch1 is granted after ch3, then `rr_ptr` = 2.
- Busy: `i_busy_r` held high for 5 cycles with 3 entries queued → no issue during those cycles. The 3 entries are issued in order starting one cycle after busy drops.
- Full/overflow, FIFO_DEPTH=8: push 9 updates back-to-back on ch2 while busy → `o_ch_rdy_r[2]` is 0 after the 8th push, the 9th update is dropped, and `o_ch_ovf_r[2]` = 1 stays set. Exactly 8 updates are issued once busy is released.
- Reset mid-operation: `arst_n` low with queued entries → all outputs 0 immediately. No stale update is issued after release, and `o_ch_rdy_r` returns to all ones one edge later.
- With `V_UPD_MUX_STATS_EN`: 300 issues from ch1 with CNT_W=8 → `o_stat_issued_r[1]` = 44.
